// File: rtl/sign_log_arbiter.sv
// sign_log_arbiter: captures mult_block signatures into a small FIFO and
// drains them into the single-port SIGN_MEM SRAM, sharing that SRAM with a
// host port. The host normally wins the SRAM. The logger takes it only when
// the FIFO is full.
// Optional feature: define SIGN_LOG_CHKSUM_EN to build the running checksum
// of logged words on o_chksum. When it is not defined, o_chksum is tied to 0.
module sign_log_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DECIM_W    = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [AW-1:0]      i_base_addr,
  input  logic [AW-1:0]      i_length,
  input  logic               i_wrap,
  input  logic [DECIM_W-1:0] i_decim,
  input  logic [DW-1:0]      i_sign,
  input  logic               i_sign_vld,
  input  logic               i_host_req,
  input  logic               i_host_we,
  input  logic [AW-1:0]      i_host_addr,
  input  logic [DW-1:0]      i_host_wdata,
  output logic               o_host_gnt,
  output logic               o_host_rvalid,
  output logic [DW-1:0]      o_host_rdata,
  output logic               o_smem_cen,
  output logic               o_smem_wen,
  output logic [AW-1:0]      o_smem_addr,
  output logic [DW-1:0]      o_smem_wdata,
  input  logic [DW-1:0]      i_smem_rdata,
  output logic               o_busy,
  output logic               o_done,
  output logic [AW-1:0]      o_wr_ptr,
  output logic [7:0]         o_ovf_cnt,
  output logic [DW-1:0]      o_chksum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, ARM, LOG, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [AW-1:0]      base_q;
  logic [AW-1:0]      length_q;
  logic               wrap_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] decim_cnt;
  logic [AW:0]        cap_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [7:0]         ovf_cnt;
  logic               host_rvalid_q;

  logic [DW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]      fifo_rd;
  logic [PW-1:0]      fifo_wr;
  logic [CW-1:0]      fifo_cnt;

  logic               start_evt;
  logic               fifo_empty;
  logic               fifo_full;
  logic               host_gnt;
  logic               pop;
  logic               cap_evt;
  logic               cap_take;
  logic               push;
  logic               drop;
  logic [AW:0]        win_len;
  logic               window_full;
  logic [AW-1:0]      win_end;
  logic [AW-1:0]      ptr_inc;
  logic [AW-1:0]      ptr_nxt;
  logic [DW-1:0]      fifo_head;

  // A session only starts from IDLE or DONE; i_start is ignored elsewhere.
  assign start_evt  = i_start && ((state == IDLE) || (state == DONE));
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem[fifo_rd];

  // The host wins the SRAM unless the FIFO is full. No access issues while reset is high.
  assign host_gnt = i_host_req && !fifo_full && !i_reset;
  assign pop      = !fifo_empty && !host_gnt && !i_reset;

  // A sample that arrives together with i_stop is never taken.
  assign cap_evt  = (state == LOG) && i_sign_vld && !i_stop;
  assign cap_take = cap_evt && (decim_cnt == '0);
  assign push     = cap_take && (!fifo_full || pop);
  assign drop     = cap_take && fifo_full && !pop;

  // A length of 0 selects the whole memory (2^AW entries).
  assign win_len     = {(length_q == '0), length_q};
  assign window_full = !wrap_q && push && ((cap_cnt + (AW+1)'(1)) == win_len);

  // Write-pointer advance. The pointer folds back to base at the end of the window in circular mode.
  assign win_end = base_q + length_q;
  assign ptr_inc = wr_ptr + AW'(1);
  assign ptr_nxt = (wrap_q && (ptr_inc == win_end)) ? base_q : ptr_inc;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic for the session FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = ARM;
      ARM:     state_nxt = LOG;
      LOG: begin
        if (i_stop)           state_nxt = DRAIN;
        else if (window_full) state_nxt = DRAIN;
      end
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    if (i_start) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the session configuration when a session starts
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      base_q   <= '0;
      length_q <= '0;
      wrap_q   <= 1'b0;
      decim_q  <= '0;
    end else if (start_evt) begin
      base_q   <= i_base_addr;
      length_q <= i_length;
      wrap_q   <= i_wrap;
      decim_q  <= i_decim;
    end
  end

  // FIFO pointers and occupancy. A push and a pop may happen in the same cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else if (start_evt) begin
      fifo_rd  <= '0;
      fifo_wr  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) fifo_wr <= fifo_wr + PW'(1);
      if (pop)  fifo_rd <= fifo_rd + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage. The data path needs no reset because occupancy guards every read.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[fifo_wr] <= i_sign;
  end

  // Decimation and capture counters. Every valid LOG sample steps the decimator.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      decim_cnt <= '0;
      cap_cnt   <= '0;
    end else if (start_evt) begin
      decim_cnt <= '0;
      cap_cnt   <= '0;
    end else begin
      if (cap_evt) decim_cnt <= (decim_cnt == '0) ? decim_q : decim_cnt - DECIM_W'(1);
      if (push)    cap_cnt   <= cap_cnt + (AW+1)'(1);
    end
  end

  // Logger write pointer. It moves only when a FIFO word is written to SRAM.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        wr_ptr <= '0;
    else if (start_evt) wr_ptr <= i_base_addr;
    else if (pop)       wr_ptr <= ptr_nxt;
  end

  // Count of dropped samples, saturating at 255
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                       ovf_cnt <= '0;
    else if (start_evt)                ovf_cnt <= '0;
    else if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
  end

  // Host read data returns one cycle after the read is issued
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) host_rvalid_q <= 1'b0;
    else         host_rvalid_q <= host_gnt && !i_host_we;
  end

  // SRAM port mux: host access, logger write, or idle
  always_comb begin
    o_smem_cen   = 1'b1;
    o_smem_wen   = 1'b1;
    o_smem_addr  = '0;
    o_smem_wdata = '0;
    if (host_gnt) begin
      o_smem_cen   = 1'b0;
      o_smem_wen   = !i_host_we;
      o_smem_addr  = i_host_addr;
      o_smem_wdata = i_host_we ? i_host_wdata : '0;
    end else if (pop) begin
      o_smem_cen   = 1'b0;
      o_smem_wen   = 1'b0;
      o_smem_addr  = wr_ptr;
      o_smem_wdata = fifo_head;
    end
  end

`ifdef SIGN_LOG_CHKSUM_EN
  logic [DW-1:0] chksum;

  // Running sum of every word the logger writes to SRAM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        chksum <= '0;
    else if (start_evt) chksum <= '0;
    else if (pop)       chksum <= chksum + fifo_head;
  end

  assign o_chksum = chksum;
`else
  assign o_chksum = '0;
`endif

  assign o_host_gnt    = host_gnt;
  assign o_host_rvalid = host_rvalid_q;
  assign o_host_rdata  = host_rvalid_q ? i_smem_rdata : '0;
  assign o_busy        = (state == ARM) || (state == LOG) || (state == DRAIN);
  assign o_done        = (state == DONE);
  assign o_wr_ptr      = wr_ptr;
  assign o_ovf_cnt     = ovf_cnt;

endmodule

// File: tb/tb_sign_log_arbiter.sv
// tb_sign_log_arbiter: directed bench for sign_log_arbiter with a behavioural SRAM model.
// The session table covers basic logging, circular wrap and decimation. Separate
// hand-written sequences cover host contention, reset in the middle of a session,
// and ignored start/stop pulses.
module tb_sign_log_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          i_clk;
  logic          i_reset;
  logic          i_start;
  logic          i_stop;
  logic [AW-1:0] i_base_addr;
  logic [AW-1:0] i_length;
  logic          i_wrap;
  logic [3:0]    i_decim;
  logic [DW-1:0] i_sign;
  logic          i_sign_vld;
  logic          i_host_req;
  logic          i_host_we;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic          o_host_gnt;
  logic          o_host_rvalid;
  logic [DW-1:0] o_host_rdata;
  logic          o_smem_cen;
  logic          o_smem_wen;
  logic [AW-1:0] o_smem_addr;
  logic [DW-1:0] o_smem_wdata;
  logic [DW-1:0] i_smem_rdata;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_wr_ptr;
  logic [7:0]    o_ovf_cnt;
  logic [DW-1:0] o_chksum;

  int pass_cnt;
  int check_cnt;

  logic [DW-1:0] sram [0:4095];

  typedef struct {
    logic [AW-1:0]       base;
    logic [AW-1:0]       len;
    logic                wrap;
    logic [3:0]          decim;
    int                  nsamp;
    logic                do_stop;
    logic [AW-1:0]       exp_ptr;
    logic [DW-1:0]       exp_chk;
    logic [3:0][AW-1:0]  addr;
    logic [3:0][DW-1:0]  data;
  } row_t;

  row_t rows [3];

  sign_log_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_base_addr(i_base_addr), .i_length(i_length), .i_wrap(i_wrap), .i_decim(i_decim),
    .i_sign(i_sign), .i_sign_vld(i_sign_vld),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
    .o_host_rdata(o_host_rdata), .o_smem_cen(o_smem_cen), .o_smem_wen(o_smem_wen),
    .o_smem_addr(o_smem_addr), .o_smem_wdata(o_smem_wdata), .i_smem_rdata(i_smem_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_wr_ptr(o_wr_ptr), .o_ovf_cnt(o_ovf_cnt),
    .o_chksum(o_chksum)
  );

  // Free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Single-port SRAM model with a one-cycle read latency
  always @(posedge i_clk) begin
    if (!o_smem_cen) begin
      if (!o_smem_wen) sram[o_smem_addr] <= o_smem_wdata;
      else             i_smem_rdata      <= sram[o_smem_addr];
    end
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input int value);
    i_sign_vld = vld;
    i_sign     = DW'(value);
  endtask

  task automatic startSession(input logic [AW-1:0] base, input logic [AW-1:0] len,
                              input logic wrap, input logic [3:0] decim);
    i_base_addr = base;
    i_length    = len;
    i_wrap      = wrap;
    i_decim     = decim;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
    checkOutput("busy_in_arm", o_busy, 1);
    step();
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!o_done && n < 200) begin
      step();
      n++;
    end
    checkOutput(name, o_done, 1);
  endtask

  task automatic setRow(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len,
                        input logic wrap, input logic [3:0] decim, input int nsamp,
                        input logic do_stop, input logic [AW-1:0] exp_ptr,
                        input logic [DW-1:0] exp_chk,
                        input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                        input logic [AW-1:0] a3, input logic [DW-1:0] d3);
    rows[idx].base    = base;
    rows[idx].len     = len;
    rows[idx].wrap    = wrap;
    rows[idx].decim   = decim;
    rows[idx].nsamp   = nsamp;
    rows[idx].do_stop = do_stop;
    rows[idx].exp_ptr = exp_ptr;
    rows[idx].exp_chk = exp_chk;
    rows[idx].addr[0] = a0; rows[idx].data[0] = d0;
    rows[idx].addr[1] = a1; rows[idx].data[1] = d1;
    rows[idx].addr[2] = a2; rows[idx].data[2] = d2;
    rows[idx].addr[3] = a3; rows[idx].data[3] = d3;
  endtask

  // Main test sequence
  initial begin
    logic [DW-1:0] exp_chk;
    logic          prev_gnt;
    logic          exp_gnt;

    pass_cnt = 0;
    check_cnt = 0;
    for (int i = 0; i < 4096; i++) sram[i] = '0;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_base_addr = '0; i_length = '0; i_wrap = 1'b0; i_decim = '0;
    i_sign = '0; i_sign_vld = 1'b0;
    i_host_req = 1'b0; i_host_we = 1'b0; i_host_addr = '0; i_host_wdata = '0;

    setRow(0, 12'h010, 12'd8, 1'b0, 4'd0, 20, 1'b0, 12'h018, 16'd36,
           12'h010, 16'd1, 12'h013, 16'd4, 12'h017, 16'd8, 12'h018, 16'd0);
    setRow(1, 12'hFFE, 12'd4, 1'b1, 4'd0, 10, 1'b1, 12'h000, 16'd55,
           12'hFFE, 16'd9, 12'hFFF, 16'd10, 12'h000, 16'd7, 12'h001, 16'd8);
    setRow(2, 12'h040, 12'd16, 1'b0, 4'd2, 12, 1'b1, 12'h044, 16'd22,
           12'h040, 16'd1, 12'h041, 16'd4, 12'h042, 16'd7, 12'h043, 16'd10);

    // Reset values
    step();
    step();
    checkOutput("rst_cen", o_smem_cen, 1);
    checkOutput("rst_wen", o_smem_wen, 1);
    checkOutput("rst_addr", o_smem_addr, 0);
    checkOutput("rst_wdata", o_smem_wdata, 0);
    checkOutput("rst_gnt", o_host_gnt, 0);
    checkOutput("rst_rvalid", o_host_rvalid, 0);
    checkOutput("rst_rdata", o_host_rdata, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_wr_ptr", o_wr_ptr, 0);
    checkOutput("rst_ovf", o_ovf_cnt, 0);
    checkOutput("rst_chksum", o_chksum, 0);
    i_reset = 1'b0;
    step();

    // Table-driven logging sessions
    for (int r = 0; r < 3; r++) begin
      startSession(rows[r].base, rows[r].len, rows[r].wrap, rows[r].decim);
      for (int k = 1; k <= rows[r].nsamp; k++) begin
        applyStimulus(1'b1, k);
        step();
      end
      applyStimulus(1'b0, 0);
      if (rows[r].do_stop) begin
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
      end
      waitDone($sformatf("row%0d_done", r));
      checkOutput($sformatf("row%0d_busy", r), o_busy, 0);
      checkOutput($sformatf("row%0d_wr_ptr", r), o_wr_ptr, rows[r].exp_ptr);
      checkOutput($sformatf("row%0d_ovf", r), o_ovf_cnt, 0);
`ifdef SIGN_LOG_CHKSUM_EN
      exp_chk = rows[r].exp_chk;
`else
      exp_chk = '0;
`endif
      checkOutput($sformatf("row%0d_chksum", r), o_chksum, exp_chk);
      for (int j = 0; j < 4; j++)
        checkOutput($sformatf("row%0d_mem%0d", r, j), sram[rows[r].addr[j]], rows[r].data[j]);
    end

    // Host write while no session is running
    i_host_req = 1'b1; i_host_we = 1'b1; i_host_addr = 12'h200; i_host_wdata = 16'hBEEF;
    @(negedge i_clk);
    checkOutput("hwr_gnt", o_host_gnt, 1);
    checkOutput("hwr_wen", o_smem_wen, 0);
    step();
    i_host_req = 1'b0; i_host_we = 1'b0;
    @(negedge i_clk);
    checkOutput("hwr_no_rvalid", o_host_rvalid, 0);
    step();

    // Host read held during LOG: the host gets four grants, then the full FIFO takes over
    startSession(12'h100, 12'd16, 1'b1, 4'd0);
    prev_gnt = 1'b0;
    for (int c = 0; c < 10; c++) begin
      i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 12'h200;
      applyStimulus(1'b1, c + 1);
      @(negedge i_clk);
      exp_gnt = (c < 4);
      checkOutput($sformatf("cont_gnt%0d", c), o_host_gnt, exp_gnt);
      checkOutput($sformatf("cont_rvalid%0d", c), o_host_rvalid, prev_gnt);
      checkOutput($sformatf("cont_rdata%0d", c), o_host_rdata, prev_gnt ? 16'hBEEF : 16'h0);
      prev_gnt = exp_gnt;
      step();
    end
    i_host_req = 1'b0;
    applyStimulus(1'b0, 0);
    @(negedge i_clk);
    checkOutput("cont_rvalid_end", o_host_rvalid, prev_gnt);
    step();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    waitDone("cont_done");
    checkOutput("cont_ovf", o_ovf_cnt, 0);
    checkOutput("cont_wr_ptr", o_wr_ptr, 12'h10A);
    checkOutput("cont_mem_first", sram[12'h100], 16'd1);
    checkOutput("cont_mem_last", sram[12'h109], 16'd10);
    checkOutput("cont_mem_host", sram[12'h200], 16'hBEEF);

    // Reset in the middle of LOG with a pending pop and a host request
    startSession(12'h300, 12'd16, 1'b1, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, k);
      step();
    end
    i_host_req = 1'b1; i_host_we = 1'b0;
    applyStimulus(1'b1, 4);
    i_reset = 1'b1;
    #1;
    checkOutput("mrst_cen", o_smem_cen, 1);
    checkOutput("mrst_gnt", o_host_gnt, 0);
    checkOutput("mrst_busy", o_busy, 0);
    checkOutput("mrst_wr_ptr", o_wr_ptr, 0);
    checkOutput("mrst_addr", o_smem_addr, 0);
    checkOutput("mrst_chksum", o_chksum, 0);
    step();
    checkOutput("mrst_cen_edge", o_smem_cen, 1);
    checkOutput("mrst_rvalid", o_host_rvalid, 0);
    i_reset = 1'b0;
    i_host_req = 1'b0;
    applyStimulus(1'b0, 0);
    step();
    checkOutput("mrst_no_write", sram[12'h302], 16'd0);
    checkOutput("mrst_idle", o_busy, 0);
    startSession(12'h310, 12'd2, 1'b0, 4'd0);
    applyStimulus(1'b1, 5);
    step();
    applyStimulus(1'b1, 6);
    step();
    applyStimulus(1'b0, 0);
    waitDone("mrst_after_done");
    checkOutput("mrst_after_ptr", o_wr_ptr, 12'h312);
    checkOutput("mrst_after_mem0", sram[12'h310], 16'd5);
    checkOutput("mrst_after_mem1", sram[12'h311], 16'd6);

    // i_start during LOG and i_stop during DONE are both ignored
    startSession(12'h400, 12'd4, 1'b0, 4'd0);
    applyStimulus(1'b1, 1);
    step();
    i_start = 1'b1; i_base_addr = 12'h500;
    applyStimulus(1'b1, 2);
    step();
    i_start = 1'b0;
    applyStimulus(1'b1, 3);
    step();
    applyStimulus(1'b1, 4);
    step();
    applyStimulus(1'b0, 0);
    waitDone("ign_done");
    checkOutput("ign_wr_ptr", o_wr_ptr, 12'h404);
    checkOutput("ign_mem1", sram[12'h401], 16'd2);
    checkOutput("ign_mem3", sram[12'h403], 16'd4);
    checkOutput("ign_mem_other", sram[12'h500], 16'd0);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    step();
    checkOutput("ign_stop_done", o_done, 1);
    checkOutput("ign_stop_busy", o_busy, 0);
    checkOutput("ign_stop_ptr", o_wr_ptr, 12'h404);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/sign_log_arbiter.md
Name: sign_log_arbiter

Overview:
Sequences capture of mult_block signatures into the single-port signature SRAM (SIGN_MEM) and shares that SRAM with an external host port. Captured signatures go into a small FIFO. The FIFO drains into SRAM whenever the host is not using it, so host accesses never lose logged samples until the FIFO overflows. The block sits in the chip core between the signature source, the host interface and SIGN_MEM.

Parameters:
AW, 12, SRAM address width
DW, 16, signature/data width
FIFO_DEPTH, 4, capture FIFO entries (power of 2, >=2)
DECIM_W, 4, decimation counter width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_start  in  1  pulse: begin logging session
i_stop  in  1  pulse: end logging session
i_base_addr  in  AW  first SRAM address of log window
i_length  in  AW  window length in entries; 0 means 2^AW
i_wrap  in  1  1 = circular log until stop; 0 = stop when window full
i_decim  in  DECIM_W  capture one sample every i_decim+1 valid cycles
i_sign  in  DW  signature sample
i_sign_vld  in  1  sample valid
i_host_req  in  1  host access request
i_host_we  in  1  1 = write, 0 = read
i_host_addr  in  AW  host address
i_host_wdata  in  DW  host write data
o_host_gnt  out  1  host access issued this cycle
o_host_rvalid  out  1  host read data valid
o_host_rdata  out  DW  host read data
o_smem_cen  out  1  SRAM chip enable, active-low
o_smem_wen  out  1  SRAM write enable, active-low
o_smem_addr  out  AW  SRAM address
o_smem_wdata  out  DW  SRAM write data
i_smem_rdata  in  DW  SRAM read data (1-cycle latency)
o_busy  out  1  state is ARM, LOG or DRAIN
o_done  out  1  session complete
o_wr_ptr  out  AW  next logger write address
o_ovf_cnt  out  8  dropped-sample count, saturating at 255
o_chksum  out  DW  logger checksum (see Optional Feature)

Behaviour:
- Reset: state IDLE; FIFO empty; all counters 0; o_smem_cen=1, o_smem_wen=1, o_smem_addr=0, o_smem_wdata=0; o_host_gnt=0, o_host_rvalid=0, o_host_rdata=0; o_busy=0, o_done=0; o_wr_ptr=0; o_ovf_cnt=0; o_chksum=0. Reset asserted mid-session aborts the session immediately. No SRAM write may issue in the cycle reset is asserted.
- FSM states: IDLE, ARM, LOG, DRAIN, DONE.
- IDLE/DONE + i_start -> ARM. On entry: latch base, length, wrap and decim; clear FIFO, capture count, decimation counter, o_ovf_cnt and o_chksum; set o_wr_ptr = base; clear o_done.
- ARM -> LOG after 1 cycle.
- In any other state, i_start is ignored. i_stop in IDLE/DONE is ignored.
- LOG capture: a valid sample is captured when the decimation counter equals 0. The counter then reloads to i_decim; otherwise it decrements on each valid sample.
- Capture with FIFO full and no pop in the same cycle: sample dropped, o_ovf_cnt increments (saturating).
- LOG with wrap=0: capture count reaching length -> DRAIN (no further captures).
- LOG + i_stop -> DRAIN; a sample arriving in the same cycle as i_stop is not captured.
- DRAIN: FIFO empty -> DONE. DONE holds o_done=1 until the next i_start.
- SRAM arbitration, one access per cycle:
  - Host wins when i_host_req=1, unless the FIFO is full and non-empty pops are pending; then the logger wins.
  - Otherwise a non-empty FIFO pops.
  - Host may access the SRAM in every state.
- SRAM outputs are combinational from the arbiter.
- Logger pop: writes FIFO head to o_wr_ptr. o_wr_ptr increments modulo 2^AW; on reaching base+length it wraps to base (window wrap). With length=0 the window is the full memory.
- Host grant:
  - o_host_gnt=1 in the issue cycle.
  - Read: o_host_rvalid=1 the following cycle, with o_host_rdata=i_smem_rdata; o_host_rdata=0 when not valid.
  - Write: no rvalid.
- Capture and pop may occur in the same cycle on a full FIFO; the capture is not dropped.

Optional Feature:
- Macro: SIGN_LOG_CHKSUM_EN.
- Defined: o_chksum accumulates the sum, modulo 2^DW, of every word the logger writes to SRAM. It is cleared in ARM and holds its value in DONE.
- Undefined: o_chksum is tied to 0 and no adder is built.

Test Plan:
- Start with base=0x010, length=8, wrap=0, decim=0, incrementing valid samples 1..20, no host -> SRAM 0x010..0x017 = 1..8; o_done=1; o_wr_ptr=0x018; o_ovf_cnt=0; o_chksum=36 with macro defined.
- base=0xFFE, length=4, wrap=1, 10 samples, then stop -> writes wrap in window 0xFFE,0xFFF,0x000,0x001; final contents 9,10,7,8.
- decim=2, 12 valid samples -> every third sample (1,4,7,10) logged.
- Host read held for 10 cycles during LOG with sample every cycle, FIFO_DEPTH=4 -> logger wins when FIFO full; o_ovf_cnt matches dropped count; each host read returns rvalid 1 cycle after gnt.
- Reset asserted mid-LOG, then released -> all outputs at reset values; o_smem_cen=1 during reset; subsequent start works normally.
- i_start pulsed during LOG -> ignored; i_stop during DONE -> ignored; o_done stays 1.
